mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the instruction-fetch stage and the memory (load/store) stage of the 5-stage MIPS pipeline.
- Serialises requests, sequences multi-cycle memory transactions and returns read data to the owning stage.
- Generates the pipeline STALL signal while any stage waits on memory.
- Data-stage priority with a starvation guard for fetch.

Parameters:
ADDR_WIDTH, 32, byte address width on all ports
DATA_WIDTH, 32, data word width
MAX_STARVE, 4, consecutive data grants allowed while fetch waits before fetch is forced ahead (range 1..15)

Ports:
clk  in  1  single clock, rising-edge
reset  in  1  asynchronous, active-low reset
enable  in  1  0 = no new grants; an in-flight transaction still completes
if_req  in  1  fetch read request; held with if_addr stable until if_done
if_addr  in  ADDR_WIDTH  fetch address
if_rdata  out  DATA_WIDTH  fetch read data; valid when if_done=1, held until next if_done
if_done  out  1  one-cycle completion pulse to fetch
dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_done
dm_we  in  1  1 = write, 0 = read
dm_addr  in  ADDR_WIDTH  data address
dm_wdata  in  DATA_WIDTH  store data
dm_rdata  out  DATA_WIDTH  load data; valid when dm_done=1, held until next dm_done
dm_done  out  1  one-cycle completion pulse to data stage
mem_valid  out  1  memory transaction request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ready
mem_ready  in  1  memory accepts/completes the transaction this cycle
stall  out  1  pipeline stall request

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE, starve_cnt=0. mem_valid, mem_we, if_done, dm_done = 0. mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
- Reset mid-transaction abandons the transaction: mem_valid drops immediately and no done pulse is issued.
- FSM states: IDLE, BUSY_F, BUSY_D. All memory-side outputs are registered.
- IDLE arbitration on each edge, only when enable=1. A requester is eligible if its req=1 and its done is not high this cycle (done-cycle masking).
  - Data eligible and (starve_cnt < MAX_STARVE or fetch not eligible) -> BUSY_D.
  - Otherwise, fetch eligible -> BUSY_F.
  - Neither eligible -> stay in IDLE.
- Entering BUSY_x latches the owner's address, we and wdata onto mem_* and sets mem_valid=1. Fetch always drives mem_we=0.
- BUSY_x: mem_valid and all mem_* outputs are held stable until a cycle with mem_ready=1. On that edge:
  - mem_valid=0 and FSM returns to IDLE.
  - The owner's done=1 for exactly one cycle.
  - For a read, mem_rdata is captured into the owner's rdata. For a write, the owner's rdata is unchanged.
- Minimum latency, req to done: request seen at edge N -> mem_valid from N; mem_ready=1 in cycle N -> done high after edge N+1. Back-to-back service is therefore one transaction per 2 cycles minimum.
- Starvation counter:
  - +1 on each data grant made while fetch is eligible, saturating at MAX_STARVE.
  - Cleared on any fetch grant, or when fetch is not requesting.
- stall is combinational: (if_req & ~if_done) | (dm_req & ~dm_done). It stays high through arbitration and the wait states.
- enable=0 suppresses only new grants. stall is still driven by the requests.
- A requester dropping req while BUSY for it is illegal; the transaction completes regardless.

Test Plan:
- Single fetch: if_addr=0x00000010, mem_ready=1 on the first mem_valid cycle, mem_rdata=0x8C220004 -> mem_valid for 1 cycle, if_done one cycle later with if_rdata=0x8C220004. stall=1 from req until the if_done cycle.
- Simultaneous requests: if_req and dm_req (write, addr 0x100, wdata 0xDEADBEEF) asserted together -> data served first (mem_we=1, mem_addr=0x100), then fetch. dm_done precedes if_done by 2 cycles with mem_ready=1 immediately.
- Starvation guard, MAX_STARVE=4: dm_req held continuously (re-issued after each done) with if_req high -> exactly 4 data grants, then a fetch grant, then data resumes.
- Wait states: mem_ready low for 3 cycles -> mem_valid, mem_addr and mem_wdata stay constant for 4 cycles. Done pulses exactly once.
- enable=0 while IDLE with requests pending -> no mem_valid, stall=1. Raising enable -> grant on the next edge.
- reset asserted during BUSY_D -> mem_valid=0 immediately, no dm_done. After release with dm_req still high -> the transaction restarts from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one memory port between fetch and data stages,
//                    data-priority arbitration with a fetch starvation guard.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_done,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_done,
    output logic                  mem_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  stall
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BUSY_F = 2'd1;
    localparam logic [1:0] c_BUSY_D = 2'd2;

    localparam logic [3:0] c_MAX_STARVE = 4'(MAX_STARVE);

    logic [1:0]            r_state;
    logic [3:0]            r_starve_cnt;
    logic                  r_mem_valid;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_dm_rdata;
    logic                  r_if_done;
    logic                  r_dm_done;

    logic                  w_if_elig;
    logic                  w_dm_elig;
    logic                  w_idle;
    logic                  w_grant_d;
    logic                  w_grant_f;

    // A requester whose done pulse is high this cycle is still holding a stale req
    assign w_if_elig = if_req & ~r_if_done;
    assign w_dm_elig = dm_req & ~r_dm_done;
    assign w_idle    = (r_state == c_IDLE);

    assign w_grant_d = enable & w_idle & w_dm_elig &
                       ((r_starve_cnt < c_MAX_STARVE) | ~w_if_elig);
    assign w_grant_f = enable & w_idle & ~w_grant_d & w_if_elig;

    assign stall     = w_if_elig | w_dm_elig;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_done   <= 1'b0;
            r_dm_done   <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_dm_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_grant_d) begin
                        r_state     <= c_BUSY_D;
                        r_mem_valid <= 1'b1;
                        r_mem_we    <= dm_we;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                    end else if (w_grant_f) begin
                        r_state     <= c_BUSY_F;
                        r_mem_valid <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                    end
                end
                c_BUSY_F: begin
                    if (mem_ready) begin
                        r_state     <= c_IDLE;
                        r_mem_valid <= 1'b0;
                        r_if_done   <= 1'b1;
                        r_if_rdata  <= mem_rdata;
                    end
                end
                c_BUSY_D: begin
                    if (mem_ready) begin
                        r_state     <= c_IDLE;
                        r_mem_valid <= 1'b0;
                        r_dm_done   <= 1'b1;
                        if (!r_mem_we) begin
                            r_dm_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_mem_valid <= 1'b0;
                end
            endcase
        end
    end

    // Counts data grants that overtook a waiting fetch; saturates at the limit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant_f || !if_req) begin
            r_starve_cnt <= 4'd0;
        end else if (w_grant_d && w_if_elig && (r_starve_cnt < c_MAX_STARVE)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    assign mem_valid = r_mem_valid;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign if_done   = r_if_done;
    assign dm_done   = r_dm_done;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter : directed scoreboard bench for mem_port_arbiter.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_txn_t;

    mem_txn_t    exp_mem[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_dm[$];

    int          checks = 0;
    int          errors = 0;
    int          cfg_wait = 0;
    int          wcnt = 0;
    logic [31:0] rdata_drv = '0;

    mem_port_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MAX_STARVE(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_done  (dm_done),
        .mem_valid(mem_valid),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    // Memory model: ready after cfg_wait wait cycles of a held request
    assign mem_ready = mem_valid && (wcnt >= cfg_wait);
    assign mem_rdata = rdata_drv;
    always @(posedge clk) wcnt <= (mem_valid && !mem_ready) ? wcnt + 1 : 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit is_dm, input int limit);
        int n = 0;
        while (!(is_dm ? dm_done : if_done) && n < limit) begin
            tick();
            n++;
        end
        if (!(is_dm ? dm_done : if_done)) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no %s done within %0d cycles", is_dm ? "dm" : "if", limit);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a handshake or done
    always @(negedge clk) begin
        mem_txn_t t;
        logic [31:0] e;
        if (mem_valid && mem_ready) begin
            if (exp_mem.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_txn: unexpected transaction addr %h, expected none", mem_addr);
            end else begin
                t = exp_mem.pop_front();
                check("mem_we", {31'd0, mem_we}, {31'd0, t.we});
                check("mem_addr", mem_addr, t.addr);
                if (t.we) check("mem_wdata", mem_wdata, t.wdata);
            end
        end
        if (if_done) begin
            if (exp_if.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL if_done: unexpected pulse rdata %h, expected none", if_rdata);
            end else begin
                e = exp_if.pop_front();
                check("if_rdata", if_rdata, e);
            end
        end
        if (dm_done) begin
            if (exp_dm.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dm_done: unexpected pulse rdata %h, expected none", dm_rdata);
            end else begin
                e = exp_dm.pop_front();
                check("dm_rdata", dm_rdata, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dm_at;
        int if_at;
        int ndm;

        // Reset state
        #1;
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
        check("rst_dones", {30'd0, if_done, dm_done}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        enable = 1'b1;
        tick();

        // Single fetch
        rdata_drv = 32'h8C220004;
        exp_mem.push_back('{1'b0, 32'h0000_0010, 32'h0});
        exp_if.push_back(32'h8C220004);
        if_req = 1'b1;
        if_addr = 32'h0000_0010;
        #1;
        check("fetch_stall_req", {31'd0, stall}, 32'd1);
        tick();
        check("fetch_mem_valid", {31'd0, mem_valid}, 32'd1);
        check("fetch_mem_addr", mem_addr, 32'h0000_0010);
        check("fetch_stall_busy", {31'd0, stall}, 32'd1);
        tick();
        check("fetch_done", {31'd0, if_done}, 32'd1);
        check("fetch_valid_drop", {31'd0, mem_valid}, 32'd0);
        check("fetch_stall_done", {31'd0, stall}, 32'd0);
        if_req = 1'b0;
        tick();
        check("fetch_done_once", {31'd0, if_done}, 32'd0);

        // Data read
        rdata_drv = 32'hCAFEF00D;
        exp_mem.push_back('{1'b0, 32'h0000_0200, 32'h0});
        exp_dm.push_back(32'hCAFEF00D);
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 32'h0000_0200;
        wait_done(1'b1, 10);
        dm_req = 1'b0;
        tick();

        // Simultaneous: data write first, then fetch; write leaves dm_rdata unchanged
        rdata_drv = 32'h12345678;
        exp_mem.push_back('{1'b1, 32'h0000_0100, 32'hDEADBEEF});
        exp_mem.push_back('{1'b0, 32'h0000_0020, 32'h0});
        exp_dm.push_back(32'hCAFEF00D);
        exp_if.push_back(32'h12345678);
        if_req = 1'b1;
        if_addr = 32'h0000_0020;
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 32'h0000_0100;
        dm_wdata = 32'hDEADBEEF;
        dm_at = -1;
        if_at = -1;
        for (int c = 0; c < 20 && (if_req || dm_req); c++) begin
            tick();
            if (c == 0) check("simul_first_we", {31'd0, mem_we}, 32'd1);
            if (dm_done) begin dm_at = c; dm_req = 1'b0; end
            if (if_done) begin if_at = c; if_req = 1'b0; end
        end
        check("simul_dm_at", dm_at, 32'd1);
        check("simul_if_at", if_at, 32'd3);
        tick();

        // Wait states: outputs held for 4 cycles, single done
        cfg_wait = 3;
        exp_mem.push_back('{1'b1, 32'h0000_0300, 32'h0BADF00D});
        exp_dm.push_back(32'hCAFEF00D);
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 32'h0000_0300;
        dm_wdata = 32'h0BADF00D;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("wait_valid", {31'd0, mem_valid}, 32'd1);
            check("wait_addr", mem_addr, 32'h0000_0300);
            check("wait_wdata", mem_wdata, 32'h0BADF00D);
            check("wait_no_done", {31'd0, dm_done}, 32'd0);
            tick();
        end
        check("wait_done", {31'd0, dm_done}, 32'd1);
        check("wait_valid_drop", {31'd0, mem_valid}, 32'd0);
        dm_req = 1'b0;
        cfg_wait = 0;
        tick();
        check("wait_done_once", {31'd0, dm_done}, 32'd0);

        // Enable low: no grant, stall still asserted
        enable = 1'b0;
        rdata_drv = 32'h11112222;
        if_req = 1'b1;
        if_addr = 32'h0000_0040;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("en0_no_valid", {31'd0, mem_valid}, 32'd0);
            check("en0_stall", {31'd0, stall}, 32'd1);
        end
        exp_mem.push_back('{1'b0, 32'h0000_0040, 32'h0});
        exp_if.push_back(32'h11112222);
        enable = 1'b1;
        tick();
        check("en1_grant", {31'd0, mem_valid}, 32'd1);
        wait_done(1'b0, 10);
        if_req = 1'b0;
        tick();

        // Starvation guard: enable dropped on each data-done cycle so data re-competes
        rdata_drv = 32'h0F0F0F0F;
        for (int i = 0; i < 4; i++) exp_mem.push_back('{1'b1, 32'h0000_0400, 32'hA5A5A5A5});
        exp_mem.push_back('{1'b0, 32'h0000_0080, 32'h0});
        exp_mem.push_back('{1'b1, 32'h0000_0400, 32'hA5A5A5A5});
        for (int i = 0; i < 5; i++) exp_dm.push_back(32'hCAFEF00D);
        exp_if.push_back(32'h0F0F0F0F);
        if_req = 1'b1;
        if_addr = 32'h0000_0080;
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 32'h0000_0400;
        dm_wdata = 32'hA5A5A5A5;
        ndm = 0;
        if_at = -1;
        for (int c = 0; c < 80 && (if_req || dm_req); c++) begin
            tick();
            enable = 1'b1;
            if (if_done) begin if_at = ndm; if_req = 1'b0; end
            if (dm_done) begin
                ndm++;
                enable = 1'b0;
                if (ndm == 5) dm_req = 1'b0;
            end
        end
        enable = 1'b1;
        check("starve_fetch_after", if_at, 32'd4);
        check("starve_dm_count", ndm, 32'd5);
        tick();

        // Reset during BUSY_D abandons the transaction; it restarts afterwards
        cfg_wait = 1000;
        dm_req = 1'b1;
        dm_we = 1'b0;
        dm_addr = 32'h0000_0500;
        tick();
        check("rstmid_busy", {31'd0, mem_valid}, 32'd1);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rstmid_valid_drop", {31'd0, mem_valid}, 32'd0);
        check("rstmid_addr", mem_addr, 32'd0);
        tick();
        check("rstmid_no_done", {31'd0, dm_done}, 32'd0);
        tick();
        check("rstmid_no_done2", {31'd0, dm_done}, 32'd0);
        cfg_wait = 0;
        rdata_drv = 32'h55AA55AA;
        exp_mem.push_back('{1'b0, 32'h0000_0500, 32'h0});
        exp_dm.push_back(32'h55AA55AA);
        reset = 1'b1;
        tick();
        check("rstmid_restart", {31'd0, mem_valid}, 32'd1);
        check("rstmid_restart_addr", mem_addr, 32'h0000_0500);
        wait_done(1'b1, 10);
        dm_req = 1'b0;
        tick();
        tick();

        check("sb_mem_empty", exp_mem.size(), 32'd0);
        check("sb_if_empty", exp_if.size(), 32'd0);
        check("sb_dm_empty", exp_dm.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
